hwf_prop_monitor: RTL and testbench
===================================

HWF_PROP_MONITOR -- requirements
Module: hwf_prop_monitor

Interface
REQ-001 SHALL have parameter NumProps, 4, number of independent property channels (1..16).
REQ-002 SHALL have parameter MaxDelay, 3, consequent window length in cycles after the antecedent cycle (0..15).
REQ-003 SHALL have parameter CntWidth, 8, width of the saturating violation counter (2..16).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en_i  input  1  global monitor enable.
REQ-007 SHALL have port ante_i  input  NumProps  per-channel antecedent.
REQ-008 SHALL have port cons_i  input  NumProps  per-channel consequent.
REQ-009 SHALL have port clr_i  input  1  single-cycle clear of sticky/counter/capture state.
REQ-010 SHALL have port viol_o  output  NumProps  one-cycle registered violation pulse per channel.
REQ-011 SHALL have port viol_sticky_o  output  NumProps  sticky violation flags.
REQ-012 SHALL have port viol_cnt_o  output  CntWidth  total violations, saturating.
REQ-013 SHALL have port first_valid_o  output  1  first-violation capture valid.
REQ-014 SHALL have port first_idx_o  output  max(1,$clog2(NumProps))  channel index of first captured violation.
REQ-015 SHALL have port pending_o  output  NumProps  channel has an open obligation.
REQ-016 SHALL have port busy_o  output  1  OR of pending_o.

Function
REQ-017 Each channel SHALL run an independent FSM, states IDLE and WAIT, plus a timer of $clog2(MaxDelay+1) bits (min 1).
REQ-018 IDLE, en_i=1, ante=1, cons=1 in cycle t: obligation met, stay IDLE.
REQ-019 IDLE, en_i=1, ante=1, cons=0, MaxDelay>0: go WAIT, timer=MaxDelay.
REQ-020 IDLE, en_i=1, ante=1, cons=0, MaxDelay=0: stay IDLE, flag violation (viol_o high in t+1).
REQ-021 WAIT, cons=1: go IDLE, no violation.
REQ-022 WAIT, cons=0, timer=1: go IDLE, flag violation; timer>1: decrement timer.
REQ-023 Net timing: antecedent in cycle t with no consequent in cycles t..t+MaxDelay SHALL produce viol_o high exactly in cycle t+MaxDelay+1.
REQ-024 ante while in WAIT SHALL be ignored (coalesced into open obligation; timer not reloaded).
REQ-025 pending_o[k] SHALL be 1 exactly while channel k is in WAIT.
REQ-026 en_i=0 SHALL force all channels to IDLE next cycle, clear timers, suppress new violations; sticky/counter/capture hold.
REQ-027 viol_sticky_o[k] SHALL set with viol_o[k] and hold until clr_i or reset.
REQ-028 viol_cnt_o SHALL add popcount of violations flagged per cycle, saturating at 2^CntWidth-1 with no wrap.
REQ-029 When first_valid_o=0 and any violation flagged, SHALL set first_valid_o and capture lowest flagged index; hold until cleared.
REQ-030 clr_i=1 SHALL clear sticky, counter, first_valid; violations flagged the same cycle SHALL then be applied (clear first, then set/count/capture).
REQ-031 clr_i SHALL NOT affect channel FSMs, timers, or viol_o.

Reset
REQ-032 rst_i SHALL asynchronously force all FSMs IDLE, timers 0, and all outputs 0 (viol_o, viol_sticky_o, viol_cnt_o, first_valid_o, first_idx_o, pending_o, busy_o).
REQ-033 Violations pending at reset assertion SHALL be discarded; no viol_o after deassertion.

Verification
REQ-034 Defaults; ante_i=0001 cycle 0, cons_i=0001 cycle 2 -> pending_o[0]=1 cycles 1-2, 0 at cycle 3; viol_o never set; viol_cnt_o=0.
REQ-035 ante_i=0010 cycle 0, cons_i=0 -> viol_o=0010 in cycle 4 only; viol_sticky_o=0010; viol_cnt_o=1; first_idx_o=1.
REQ-036 ante_i=1100 cycle 0, no cons -> viol_o=1100 cycle 4; viol_cnt_o=2; first_idx_o=2; later ch0 violation leaves first_idx_o=2.
REQ-037 CntWidth=2, five sequential violations on ch0 -> viol_cnt_o=1,2,3,3,3.
REQ-038 ante_i=0001 cycle 0, rst_i pulse cycle 2 -> pending_o=0 immediately; no viol_o through cycle 10.
REQ-039 clr_i in same cycle ch3 violation is flagged -> next cycle viol_cnt_o=1, viol_sticky_o=1000, first_idx_o=3 regardless of prior values.

Source files
------------

// File: rtl/hwf_prop_monitor.sv
// Bounded-response property monitor: each channel checks that an antecedent is
// answered by a consequent within MaxDelay cycles, with sticky/count/first-capture status.
module hwf_prop_monitor #(
    parameter int unsigned NumProps = 4,
    parameter int unsigned MaxDelay = 3,
    parameter int unsigned CntWidth = 8,
    localparam int unsigned IdxWidth = (NumProps > 1) ? $clog2(NumProps) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [NumProps-1:0] ante_i,
    input  logic [NumProps-1:0] cons_i,
    input  logic                clr_i,
    output logic [NumProps-1:0] viol_o,
    output logic [NumProps-1:0] viol_sticky_o,
    output logic [CntWidth-1:0] viol_cnt_o,
    output logic                first_valid_o,
    output logic [IdxWidth-1:0] first_idx_o,
    output logic [NumProps-1:0] pending_o,
    output logic                busy_o
);

    localparam int unsigned TimerWidth = (MaxDelay > 0) ? $clog2(MaxDelay + 1) : 1;
    localparam int unsigned SumWidth   = CntWidth + 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                state_q [NumProps];
    state_t                state_d [NumProps];
    logic [TimerWidth-1:0] timer_q [NumProps];
    logic [TimerWidth-1:0] timer_d [NumProps];
    logic [NumProps-1:0]   flag;

    logic [NumProps-1:0]   sticky_d;
    logic [CntWidth-1:0]   cnt_base;
    logic [CntWidth-1:0]   cnt_d;
    logic [SumWidth-1:0]   cnt_sum;
    logic [4:0]            pop;
    logic                  first_valid_d;
    logic [IdxWidth-1:0]   first_idx_d;
    logic [IdxWidth-1:0]   idx_low;
    logic                  found;

    // Per-channel next state; an antecedent seen while waiting is folded into the open obligation.
    always_comb begin
        flag = '0;
        for (int unsigned k = 0; k < NumProps; k++) begin
            state_d[k] = state_q[k];
            timer_d[k] = timer_q[k];
            if (!en_i) begin
                state_d[k] = IDLE;
                timer_d[k] = '0;
            end else begin
                case (state_q[k])
                    IDLE: begin
                        if (ante_i[k] && !cons_i[k]) begin
                            if (MaxDelay == 0) begin
                                flag[k] = 1'b1;
                            end else begin
                                state_d[k] = WAIT;
                                timer_d[k] = TimerWidth'(MaxDelay);
                            end
                        end
                    end
                    WAIT: begin
                        if (cons_i[k]) begin
                            state_d[k] = IDLE;
                            timer_d[k] = '0;
                        end else if (timer_q[k] == TimerWidth'(1)) begin
                            state_d[k] = IDLE;
                            timer_d[k] = '0;
                            flag[k]    = 1'b1;
                        end else begin
                            timer_d[k] = timer_q[k] - TimerWidth'(1);
                        end
                    end
                    default: begin
                        state_d[k] = IDLE;
                        timer_d[k] = '0;
                    end
                endcase
            end
        end
    end

    // Clear is applied before this cycle's violations so a same-cycle violation survives it.
    always_comb begin
        pop     = '0;
        idx_low = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NumProps; k++) begin
            pop = pop + 5'(flag[k]);
            if (flag[k] && !found) begin
                idx_low = IdxWidth'(k);
                found   = 1'b1;
            end
        end

        sticky_d = (clr_i ? '0 : viol_sticky_o) | flag;
        cnt_base = clr_i ? '0 : viol_cnt_o;
        cnt_sum  = SumWidth'(cnt_base) + SumWidth'(pop);
        if (|cnt_sum[SumWidth-1:CntWidth]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[CntWidth-1:0];
        end

        first_valid_d = clr_i ? 1'b0 : first_valid_o;
        first_idx_d   = first_idx_o;
        if (!first_valid_d && found) begin
            first_valid_d = 1'b1;
            first_idx_d   = idx_low;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NumProps; k++) begin
                state_q[k] <= IDLE;
                timer_q[k] <= '0;
            end
            viol_o        <= '0;
            viol_sticky_o <= '0;
            viol_cnt_o    <= '0;
            first_valid_o <= 1'b0;
            first_idx_o   <= '0;
        end else begin
            for (int unsigned k = 0; k < NumProps; k++) begin
                state_q[k] <= state_d[k];
                timer_q[k] <= timer_d[k];
            end
            viol_o        <= flag;
            viol_sticky_o <= sticky_d;
            viol_cnt_o    <= cnt_d;
            first_valid_o <= first_valid_d;
            first_idx_o   <= first_idx_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NumProps; k++) begin
            pending_o[k] = (state_q[k] == WAIT);
        end
        busy_o = |pending_o;
    end

endmodule

// File: tb/tb_hwf_prop_monitor.sv
// Directed-vector bench for hwf_prop_monitor: default build, a 2-bit counter build
// and a zero-window single-channel build.
module tb_hwf_prop_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] ante = '0;
    logic [3:0] cons = '0;
    logic [3:0] viol, sticky, pend;
    logic [7:0] cnt;
    logic       fv, busy;
    logic [1:0] idx;

    logic [3:0] ante2 = '0;
    logic [3:0] viol2, sticky2, pend2;
    logic [1:0] cnt2, idx2;
    logic       fv2, busy2;

    logic       ante3 = 1'b0;
    logic       cons3 = 1'b0;
    logic       viol3, sticky3, pend3, fv3, busy3, idx3;
    logic [1:0] cnt3;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    hwf_prop_monitor dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .ante_i(ante), .cons_i(cons), .clr_i(clr),
        .viol_o(viol), .viol_sticky_o(sticky), .viol_cnt_o(cnt), .first_valid_o(fv),
        .first_idx_o(idx), .pending_o(pend), .busy_o(busy)
    );

    hwf_prop_monitor #(.CntWidth(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(1'b1), .ante_i(ante2), .cons_i(4'b0000), .clr_i(1'b0),
        .viol_o(viol2), .viol_sticky_o(sticky2), .viol_cnt_o(cnt2), .first_valid_o(fv2),
        .first_idx_o(idx2), .pending_o(pend2), .busy_o(busy2)
    );

    hwf_prop_monitor #(.NumProps(1), .MaxDelay(0), .CntWidth(2)) dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(1'b1), .ante_i(ante3), .cons_i(cons3), .clr_i(1'b0),
        .viol_o(viol3), .viol_sticky_o(sticky3), .viol_cnt_o(cnt3), .first_valid_o(fv3),
        .first_idx_o(idx3), .pending_o(pend3), .busy_o(busy3)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] ante;
        logic [3:0] cons;
        logic [3:0] viol;
        logic [3:0] sticky;
        logic [7:0] cnt;
        logic       fv;
        logic [1:0] idx;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic c, input logic [3:0] a, input logic [3:0] q,
                       input logic [3:0] v, input logic [3:0] s, input logic [7:0] n,
                       input logic f, input logic [1:0] x, input logic [3:0] p);
        vec_t r;
        r.en = e; r.clr = c; r.ante = a; r.cons = q; r.viol = v; r.sticky = s;
        r.cnt = n; r.fv = f; r.idx = x; r.pend = p;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt2[5] = '{1, 2, 3, 3, 3};

    initial begin
        //   en clr ante     cons     | viol     sticky   cnt fv idx pend
        add(1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001);
        add(1, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010);
        add(1, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1, 1, 1, 4'b0000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, 1, 1, 4'b0000);
        add(1, 1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b1100);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b1100);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b1100);
        add(1, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 2, 1, 2, 4'b0000);
        add(1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b1100, 2, 1, 2, 4'b0001);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 2, 1, 2, 4'b0001);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 2, 1, 2, 4'b0001);
        add(1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b1101, 3, 1, 2, 4'b0000);
        add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b1101, 3, 1, 2, 4'b0100);
        add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b1101, 3, 1, 2, 4'b0100);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 3, 1, 2, 4'b0100);
        add(1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1101, 4, 1, 2, 4'b0000);
        add(1, 0, 4'b1111, 4'b1111, 4'b0000, 4'b1101, 4, 1, 2, 4'b0000);
        add(1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b1000);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b0000);
        add(0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b0000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b0000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b0000);
        add(1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b1000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b1000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4, 1, 2, 4'b1000);
        add(1, 1, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1, 1, 3, 4'b0000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1, 1, 3, 4'b0000);
        add(1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 1, 1, 3, 4'b0001);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1, 1, 3, 4'b0001);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1, 1, 3, 4'b0001);
        add(1, 0, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 1, 1, 3, 4'b0000);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1, 1, 3, 4'b0000);

        #1;
        chk("rst.viol", viol, 0);
        chk("rst.sticky", sticky, 0);
        chk("rst.cnt", cnt, 0);
        chk("rst.fv", fv, 0);
        chk("rst.idx", idx, 0);
        chk("rst.pend", pend, 0);
        chk("rst.busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            en = vecs[i].en; clr = vecs[i].clr; ante = vecs[i].ante; cons = vecs[i].cons;
            tick();
            chk($sformatf("v%0d.viol", i), viol, vecs[i].viol);
            chk($sformatf("v%0d.sticky", i), sticky, vecs[i].sticky);
            chk($sformatf("v%0d.cnt", i), cnt, vecs[i].cnt);
            chk($sformatf("v%0d.fv", i), fv, vecs[i].fv);
            chk($sformatf("v%0d.idx", i), idx, vecs[i].idx);
            chk($sformatf("v%0d.pend", i), pend, vecs[i].pend);
            chk($sformatf("v%0d.busy", i), busy, |vecs[i].pend);
        end
        en = 1'b1; clr = 1'b0; ante = '0; cons = '0;

        // Saturating 2-bit counter: five back-to-back channel-0 timeouts.
        for (int v = 0; v < 5; v++) begin
            ante2 = 4'b0001;
            tick();
            ante2 = 4'b0000;
            repeat (3) tick();
            chk($sformatf("sat%0d.viol", v), viol2, 4'b0001);
            chk($sformatf("sat%0d.cnt", v), cnt2, exp_cnt2[v]);
        end

        // Zero-length window: violation one cycle after an unanswered antecedent.
        ante3 = 1'b1; cons3 = 1'b0;
        tick();
        chk("zw.viol", viol3, 1);
        chk("zw.pend", pend3, 0);
        chk("zw.cnt", cnt3, 1);
        ante3 = 1'b1; cons3 = 1'b1;
        tick();
        chk("zw.met", viol3, 0);
        ante3 = 1'b0; cons3 = 1'b0;
        tick();
        chk("zw.idle", viol3, 0);
        chk("zw.sticky", sticky3, 1);

        // Asynchronous reset mid-obligation discards the pending violation.
        ante = 4'b0001;
        tick();
        ante = 4'b0000;
        tick();
        chk("ar.pend_before", pend, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("ar.pend", pend, 0);
        chk("ar.busy", busy, 0);
        chk("ar.sticky", sticky, 0);
        chk("ar.cnt", cnt, 0);
        chk("ar.fv", fv, 0);
        #2 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("ar.viol%0d", c), viol, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
